// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int BTN_DEBOUNCE_DEFAULT = 60000;
  localparam int BTN_LONG_DEFAULT     = 12000000;

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to 0.
module btn_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounced push-button front end: level, press/release pulses and sticky go_req/go_ack.
// Optional long-press pulse is built when BTN_CONDITIONER_LONG_PRESS_EN is defined.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = BTN_LONG_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic go_ack,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic go_req
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  logic          s;
  btn_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          press_nxt, release_nxt, level_nxt;

  btn_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (~btn_n),
    .q   (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (s) state_nxt = PRESS_WAIT;
      PRESS_WAIT: begin
        if (!s)                   state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = HELD;
      end
      HELD:         if (!s) state_nxt = RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (s)                    state_nxt = HELD;
        else if (cnt == CNT_LAST) state_nxt = IDLE;
      end
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    press_nxt   = (state == PRESS_WAIT)   && (state_nxt == HELD);
    release_nxt = (state == RELEASE_WAIT) && (state_nxt == IDLE);
    level_nxt   = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
  end

  // Counter restarts on every state change, so a bounce always costs a full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == PRESS_WAIT || state == RELEASE_WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A press in the same cycle as go_ack (either edge of the pulse) keeps the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      go_req      <= 1'b0;
    end else begin
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      go_req      <= press_nxt | btn_press | (go_req & ~go_ack);
    end
  end

`ifdef BTN_CONDITIONER_LONG_PRESS_EN
  localparam int            HW        = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold;
  logic          long_done;

  // Hold time runs across RELEASE_WAIT bounces; only a fresh press restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      long_done <= 1'b0;
      btn_long  <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (press_nxt) begin
        hold      <= '0;
        long_done <= 1'b0;
      end else if (state == HELD || state == RELEASE_WAIT) begin
        if (hold != HOLD_LAST) begin
          hold <= hold + 1'b1;
        end else if (!long_done) begin
          btn_long  <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized and directed bench for btn_conditioner against a run-length reference model.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_n = 1'b1;
  logic go_ack = 1'b0;
  logic btn_level, btn_press, btn_release, btn_long, go_req;

  int total = 0;
  int bad = 0;
  int edge_no = 0;
  int press_edge, release_edge, long_edge, npress;

  // Reference model state: raw-sample pipeline, debounced level, run of disagreeing samples.
  bit m_sy0, m_sy1, m_lvl, m_press, m_release, m_long, m_go;
  int m_run, m_since;

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .go_ack      (go_ack),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .go_req      (go_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_sy0 = 0; m_sy1 = 0; m_lvl = 0;
    m_press = 0; m_release = 0; m_long = 0; m_go = 0;
    m_run = 0; m_since = L + 1;
  endfunction

  // A level change is accepted once the synchronized pin has disagreed with the
  // current level for D+1 consecutive samples; long fires L edges after a press.
  function automatic void model_edge();
    bit s_fsm, prev_press, prev_lvl;
    s_fsm = m_sy1;
    m_sy1 = m_sy0;
    m_sy0 = ~btn_n;
    prev_press = m_press;
    prev_lvl = m_lvl;
    m_press = 0; m_release = 0; m_long = 0;
    if (prev_lvl) begin
      m_since++;
      if (m_since == L) m_long = 1;
    end
    if (s_fsm != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_lvl = ~m_lvl;
      m_run = 0;
      if (m_lvl) begin
        m_press = 1;
        m_since = 0;
      end else begin
        m_release = 1;
      end
    end
    m_go = m_press | prev_press | (m_go & ~go_ack);
  endfunction

  task automatic tick();
    bit exp_long;
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
`ifdef BTN_CONDITIONER_LONG_PRESS_EN
    exp_long = m_long;
`else
    exp_long = 0;
`endif
    chk("level", btn_level, m_lvl);
    chk("press", btn_press, m_press);
    chk("release", btn_release, m_release);
    chk("long", btn_long, exp_long);
    chk("go_req", go_req, m_go);
    if (btn_press === 1'b1) begin press_edge = edge_no; npress++; end
    if (btn_release === 1'b1) release_edge = edge_no;
    if (btn_long === 1'b1) long_edge = edge_no;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_level", btn_level, 0);
    chk("rst_go_req", go_req, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_no = 0;
    press_edge = -1; release_edge = -1; long_edge = -1; npress = 0;

    // Clean press from edge 10, held 20 cycles past the press, then release.
    ticks(9);
    btn_n = 1'b0;
    ticks(27);
    chk("clean_press_edge", press_edge, 16);
    chk("clean_npress", npress, 1);
`ifdef BTN_CONDITIONER_LONG_PRESS_EN
    chk("long_edge", long_edge, 26);
`else
    chk("long_none", long_edge, -1);
`endif
    btn_n = 1'b1;
    base = edge_no + 1;
    ticks(10);
    chk("release_edge", release_edge - base, 6);

    // Bounce: low 2, high 1, then steady low.
    npress = 0;
    btn_n = 1'b0; ticks(2);
    btn_n = 1'b1; ticks(1);
    btn_n = 1'b0;
    base = edge_no + 1;
    ticks(10);
    chk("bounce_press_delay", press_edge - base, 6);
    chk("bounce_npress", npress, 1);

    // Acknowledge five cycles after the press.
    tick();
    go_ack = 1'b1; tick();
    go_ack = 1'b0;
    chk("ack_clear", go_req, 0);

    // Release, press again and acknowledge in the cycle the press pulse is high.
    btn_n = 1'b1; ticks(10);
    btn_n = 1'b0;
    for (int i = 0; i < 12 && !m_press; i++) tick();
    chk("coincide_press_seen", btn_press, 1);
    go_ack = 1'b1; tick();
    go_ack = 1'b0;
    chk("coincide_go", go_req, 1);

    // Reset while the button is held in the press-debounce window.
    btn_n = 1'b1; ticks(10);
    btn_n = 1'b0; ticks(4);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_level", btn_level, 0);
    chk("midrst_press", btn_press, 0);
    chk("midrst_release", btn_release, 0);
    chk("midrst_long", btn_long, 0);
    chk("midrst_go_req", go_req, 0);
    @(negedge clk);
    rst = 1'b0;
    base = edge_no + 1;
    press_edge = -1;
    ticks(10);
    chk("postrst_press_delay", press_edge - base, 6);

    // Random runs: mostly bounce-length, sometimes long holds, random acks.
    for (int r = 0; r < 150; r++) begin
      int len;
      btn_n = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        go_ack = ($urandom_range(0, 5) == 0);
        tick();
      end
    end
    go_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioner for an active-low mechanical push button, directly upstream of the go/reset-driven Moore counting FSM. It synchronizes the raw pin into `clk`, debounces it with a four-state FSM, and produces a clean active-high level, one-cycle press/release pulses and a sticky request/acknowledge pair. The sticky request lets a downstream FSM on a slow divided clock still see the press.

## Interface
- `DEBOUNCE_CYCLES`, default 60000: stable cycles required to accept an edge (5 ms at 12 MHz); legal range ≥ 2.
- `LONG_CYCLES`, default 12000000: held cycles before a long-press pulse (1 s at 12 MHz); legal range ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_n`  in  1  raw button pin, active-low, asynchronous to `clk`.
- `go_ack`  in  1  downstream acknowledge, `clk` domain.
- `btn_level`  out  1  debounced pressed level, active-high.
- `btn_press`  out  1  one-cycle pulse on an accepted press.
- `btn_release`  out  1  one-cycle pulse on an accepted release.
- `btn_long`  out  1  one-cycle long-press pulse; tied 0 when the feature is compiled out.
- `go_req`  out  1  sticky request, set by press, cleared by `go_ack`.

## Operation
- Synchronizer: `btn_n` is inverted and passed through 2 flops, giving `s`. Both flops reset to 0, which means "released".
- The debounce counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide and clears on every state change.
- FSM states:
  - IDLE: released and stable. `s=1` → PRESS_WAIT, `cnt<=0`.
  - PRESS_WAIT: `s=0` → IDLE, no pulse (bounce rejected). `s=1` and `cnt==DEBOUNCE_CYCLES-1` → HELD and `btn_press` asserted. Otherwise `cnt++`.
  - HELD: pressed and stable. `s=0` → RELEASE_WAIT, `cnt<=0`.
  - RELEASE_WAIT: `s=1` → HELD, no pulse. `s=0` and `cnt==DEBOUNCE_CYCLES-1` → IDLE and `btn_release` asserted. Otherwise `cnt++`.
  - Any unused encoding → IDLE.
- `btn_level` is 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT. All outputs are registered.
- `go_req`:
  - Set on the cycle `btn_press` is asserted.
  - Cleared on a cycle with `go_ack=1`.
  - If press and ack coincide, press wins and `go_req` stays 1.
  - `go_ack` while `go_req=0` is ignored.
- Reset, including mid-operation: state IDLE, counters 0, synchronizer 0, all outputs 0. No pulse is generated on reset release, even if the button is held; the press must then pass the full debounce from IDLE.

## Timing
- Let N be the first `clk` edge that samples `btn_n=0`.
- `s` is high after edge N+1; the FSM enters PRESS_WAIT at edge N+2.
- `btn_press`, `btn_level` and `go_req` rise after edge N+2+DEBOUNCE_CYCLES. Press latency is DEBOUNCE_CYCLES+3 edges.
- Release is symmetric: `btn_release` is high and `btn_level` low after edge M+2+DEBOUNCE_CYCLES, where M is the first edge sampling `btn_n=1`.
- `btn_press`, `btn_release` and `btn_long` are exactly one cycle wide.
- `go_req` clears the cycle after the `go_ack` sample edge.

## Configuration
- Macro: `BTN_CONDITIONER_LONG_PRESS_EN`.
- Defined:
  - A hold counter of `$clog2(LONG_CYCLES)` bits clears on entry to HELD and counts while in HELD or RELEASE_WAIT.
  - When it reaches `LONG_CYCLES-1`, `btn_long` pulses once and the counter saturates.
  - No further long pulses occur until the FSM returns to IDLE.
  - A bounce back from RELEASE_WAIT to HELD does not restart the hold counter.
- Undefined: no hold counter logic; `btn_long` is constant 0; `LONG_CYCLES` is unused.

## Structure
- Shared package `btn_pkg` holds:
  - the state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - default constants `BTN_DEBOUNCE_DEFAULT` = 60000 and `BTN_LONG_DEFAULT` = 12000000.
- One sub-module, `btn_sync2`: a 2-flop synchronizer with async reset, value 0.
- FSM, counters and handshake live in the top module.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=10, macro defined unless noted.
- Clean press: `btn_n` low from edge 10 → `btn_press` and `go_req` high after edge 16, pulse 1 cycle wide, `btn_level` stays 1.
- Bounce: `btn_n` low 2 cycles, high 1, low steady → no pulse during the bounce; a single `btn_press` arrives 4+2 edges after the final low sample.
- Handshake: press, then `go_ack` pulse 5 cycles later → `go_req` falls one cycle after ack. A second press coinciding with ack keeps `go_req`=1.
- Long press: hold 20 cycles past press → exactly one `btn_long`, 10 cycles after `btn_press`. Release → `btn_release` 6 edges after the release sample. With the macro undefined, `btn_long` never asserts.
- Reset mid-press: assert `rst` during PRESS_WAIT with button held → all outputs 0 immediately. After deassert, `btn_press` appears only after the full 2+4 cycle latency.
